// File: rtl/video_pkg.sv
// -----------------------------------------------------------------------------
// video_pkg
//   Shared definitions for the scanline fetch path: default video geometry,
//   memory burst shape and the fetch FSM state type.
//   No ports; imported by video_line_fetcher.
// -----------------------------------------------------------------------------
package video_pkg;

    // Default active geometry of the display mode.
    localparam int WIDTH_DEF      = 400;
    localparam int HEIGHT_DEF     = 360;

    // Default memory interface shape.
    localparam int BURST_LEN_DEF  = 8;
    localparam int ADDR_WIDTH_DEF = 25;

    // Fetch sequencer states.
    //   IDLE : waiting for a vsync / hblank trigger
    //   REQ  : burst request outstanding, waiting for mem_ack
    //   DATA : collecting the BURST_LEN beats of the accepted burst
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        DATA = 2'd2
    } fetch_state_t;

endpackage : video_pkg

// File: rtl/video_line_fetcher.sv
// -----------------------------------------------------------------------------
// video_line_fetcher
//   Fetches the next scanline from the framebuffer into a two-bank line buffer,
//   one line ahead of scan-out. A vsync pulse queues line 0; each hblank rising
//   edge on line y queues line y+1. A line is read as a sequence of fixed-length
//   bursts; every returned beat is written to bank line[0] of the line buffer.
//   A trigger that arrives while a fetch is still running is dropped and flagged.
//
// Ports
//   clk            in   video pixel clock
//   reset          in   asynchronous, active-high reset
//   fb_base        in   framebuffer base word address, captured on vsync
//   hblank         in   high while x >= WIDTH
//   vsync          in   one-cycle frame pulse
//   y              in   current line from the timing counter
//   mem_req        out  burst request, held until mem_ack
//   mem_addr       out  burst start word address, stable while mem_req is high
//   mem_ack        in   one-cycle request accept
//   mem_rvalid     in   read data beat valid
//   mem_rdata      in   read data
//   lb_we          out  line buffer write strobe
//   lb_bank        out  line buffer bank being written
//   lb_waddr       out  word index within the line
//   lb_wdata       out  line buffer write data
//   disp_bank      out  bank read by pixel output (registered y[0])
//   line_done      out  pulse together with the last word of a line
//   overrun        out  pulse: trigger arrived while a fetch was busy
//   overrun_sticky out  set by overrun, cleared only by reset
// -----------------------------------------------------------------------------
module video_line_fetcher
    import video_pkg::*;
#(
    parameter int WIDTH          = WIDTH_DEF,
    parameter int HEIGHT         = HEIGHT_DEF,
    parameter int WORDS_PER_LINE = WIDTH / 2,
    parameter int BURST_LEN      = BURST_LEN_DEF,
    parameter int ADDR_WIDTH     = ADDR_WIDTH_DEF
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [ADDR_WIDTH-1:0] fb_base,
    input  logic                  hblank,
    input  logic                  vsync,
    input  logic [9:0]            y,
    output logic                  mem_req,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    input  logic                  mem_ack,
    input  logic                  mem_rvalid,
    input  logic [31:0]           mem_rdata,
    output logic                  lb_we,
    output logic                  lb_bank,
    output logic [7:0]            lb_waddr,
    output logic [31:0]           lb_wdata,
    output logic                  disp_bank,
    output logic                  line_done,
    output logic                  overrun,
    output logic                  overrun_sticky
);

    localparam int                BEAT_W      = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;
    localparam logic [BEAT_W-1:0] LAST_BEAT   = BEAT_W'(BURST_LEN - 1);
    localparam logic [7:0]        LAST_WORD   = 8'(WORDS_PER_LINE - 1);
    // Hblank edges on the last active line and below have no next line to fetch.
    localparam logic [9:0]        LAST_TRIG_Y = 10'(HEIGHT - 1);

    // -------------------------------------------------------------------------
    // Trigger detection
    // -------------------------------------------------------------------------
    logic                  hblank_q;
    logic                  trig_d,      trig_q;
    logic [9:0]            trig_line_d, trig_line_q;
    logic [ADDR_WIDTH-1:0] fb_base_q;

    // NOTE: every signal assigned in always_comb gets a default first, so no
    // path through the block leaves it unassigned and no latch is inferred.
    always_comb begin
        trig_d      = 1'b0;
        trig_line_d = '0;
        if (vsync) begin
            trig_d      = 1'b1;
            trig_line_d = '0;
        end else if (hblank && !hblank_q && (y < LAST_TRIG_Y)) begin
            trig_d      = 1'b1;
            trig_line_d = y + 10'd1;
        end
    end

    // NOTE: sequential state uses non-blocking assignments only, so every
    // register samples the pre-edge value of every other register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            hblank_q    <= 1'b0;
            trig_q      <= 1'b0;
            trig_line_q <= '0;
            fb_base_q   <= '0;
        end else begin
            hblank_q    <= hblank;
            trig_q      <= trig_d;
            trig_line_q <= trig_line_d;
            if (vsync) begin
                fb_base_q <= fb_base;
            end
        end
    end

    // Word offset of the triggered line inside the framebuffer; the product is
    // a constant multiply and wraps with the address space.
    logic [ADDR_WIDTH-1:0] line_off;
    assign line_off = ADDR_WIDTH'(32'(trig_line_q) * 32'(WORDS_PER_LINE));

    // -------------------------------------------------------------------------
    // Fetch sequencer
    // -------------------------------------------------------------------------
    fetch_state_t          state_q;
    logic                  bank_q;       // bank of the line being fetched
    logic [7:0]            word_idx_q;   // next word of the line to be written
    logic [BEAT_W-1:0]     beat_q;       // beat within the current burst
    logic                  mem_req_q;
    logic [ADDR_WIDTH-1:0] mem_addr_q;
    logic                  lb_we_q;
    logic                  lb_bank_q;
    logic [7:0]            lb_waddr_q;
    logic [31:0]           lb_wdata_q;
    logic                  disp_bank_q;
    logic                  line_done_q;
    logic                  overrun_q;
    logic                  overrun_sticky_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q          <= IDLE;
            bank_q           <= 1'b0;
            word_idx_q       <= '0;
            beat_q           <= '0;
            mem_req_q        <= 1'b0;
            mem_addr_q       <= '0;
            lb_we_q          <= 1'b0;
            lb_bank_q        <= 1'b0;
            lb_waddr_q       <= '0;
            lb_wdata_q       <= '0;
            disp_bank_q      <= 1'b0;
            line_done_q      <= 1'b0;
            overrun_q        <= 1'b0;
            overrun_sticky_q <= 1'b0;
        end else begin
            // Single-cycle strobes fall back to 0 unless re-asserted below.
            lb_we_q     <= 1'b0;
            line_done_q <= 1'b0;
            overrun_q   <= 1'b0;
            disp_bank_q <= y[0];

            // A trigger that finds the sequencer busy is reported and dropped;
            // the running fetch carries on untouched.
            if (trig_q && (state_q != IDLE)) begin
                overrun_q        <= 1'b1;
                overrun_sticky_q <= 1'b1;
            end

            unique case (state_q)
                IDLE: begin
                    if (trig_q) begin
                        state_q    <= REQ;
                        bank_q     <= trig_line_q[0];
                        word_idx_q <= '0;
                        beat_q     <= '0;
                        mem_req_q  <= 1'b1;
                        mem_addr_q <= fb_base_q + line_off;
                    end
                end

                REQ: begin
                    if (mem_ack) begin
                        state_q   <= DATA;
                        mem_req_q <= 1'b0;
                        beat_q    <= '0;
                    end
                end

                DATA: begin
                    if (mem_rvalid) begin
                        lb_we_q    <= 1'b1;
                        lb_bank_q  <= bank_q;
                        lb_waddr_q <= word_idx_q;
                        lb_wdata_q <= mem_rdata;
                        word_idx_q <= word_idx_q + 8'd1;
                        beat_q     <= beat_q + BEAT_W'(1);
                        if (beat_q == LAST_BEAT) begin
                            if (word_idx_q == LAST_WORD) begin
                                state_q     <= IDLE;
                                line_done_q <= 1'b1;
                            end else begin
                                // Bursts of a line are contiguous, so the next
                                // start address is the previous one plus a burst.
                                state_q    <= REQ;
                                mem_req_q  <= 1'b1;
                                mem_addr_q <= mem_addr_q + ADDR_WIDTH'(BURST_LEN);
                            end
                        end
                    end
                end

                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign mem_req        = mem_req_q;
    assign mem_addr       = mem_addr_q;
    assign lb_we          = lb_we_q;
    assign lb_bank        = lb_bank_q;
    assign lb_waddr       = lb_waddr_q;
    assign lb_wdata       = lb_wdata_q;
    assign disp_bank      = disp_bank_q;
    assign line_done      = line_done_q;
    assign overrun        = overrun_q;
    assign overrun_sticky = overrun_sticky_q;

endmodule : video_line_fetcher

// File: tb/tb_video_line_fetcher.sv
// -----------------------------------------------------------------------------
// tb_video_line_fetcher
//   Directed bench for video_line_fetcher. A memory responder acknowledges
//   requests after a fixed delay and streams one beat per cycle; it derives the
//   expected burst address from base + line*200 + words already delivered and
//   queues the expected line-buffer write for each beat. A negedge compare
//   process checks every write strobe, line_done and disp_bank against that.
// -----------------------------------------------------------------------------
module tb_video_line_fetcher;

    localparam int AW  = 25;
    localparam int WPL = 200;
    localparam int BL  = 8;

    logic          clk = 1'b0;
    logic          reset;
    logic [AW-1:0] fb_base;
    logic          hblank;
    logic          vsync;
    logic [9:0]    y;
    logic          mem_req;
    logic [AW-1:0] mem_addr;
    logic          mem_ack;
    logic          mem_rvalid;
    logic [31:0]   mem_rdata;
    logic          lb_we;
    logic          lb_bank;
    logic [7:0]    lb_waddr;
    logic [31:0]   lb_wdata;
    logic          disp_bank;
    logic          line_done;
    logic          overrun;
    logic          overrun_sticky;

    always #5 clk = ~clk;

    video_line_fetcher dut (
        .clk            (clk),
        .reset          (reset),
        .fb_base        (fb_base),
        .hblank         (hblank),
        .vsync          (vsync),
        .y              (y),
        .mem_req        (mem_req),
        .mem_addr       (mem_addr),
        .mem_ack        (mem_ack),
        .mem_rvalid     (mem_rvalid),
        .mem_rdata      (mem_rdata),
        .lb_we          (lb_we),
        .lb_bank        (lb_bank),
        .lb_waddr       (lb_waddr),
        .lb_wdata       (lb_wdata),
        .disp_bank      (disp_bank),
        .line_done      (line_done),
        .overrun        (overrun),
        .overrun_sticky (overrun_sticky)
    );

    typedef struct packed {
        logic        bank;
        logic [7:0]  waddr;
        logic [31:0] data;
    } wr_t;

    wr_t exp_q[$];

    int chk_cnt  = 0;
    int pass_cnt = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        chk_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    endtask

    // Model of the line currently being fetched.
    logic [AW-1:0] exp_fb;
    int            exp_line;
    int            words_sent;
    int            bursts;
    logic [AW-1:0] first_addr;
    logic [AW-1:0] last_addr;

    function automatic logic [AW-1:0] model_addr();
        logic [63:0] full;
        full = 64'(exp_fb) + 64'(exp_line) * 64'(WPL) + 64'(words_sent);
        return full[AW-1:0];
    endfunction

    function automatic logic [31:0] data_of(input logic [AW-1:0] a);
        return (32'(a) * 32'd2654435761) ^ 32'h5EED_0000;
    endfunction

    // ---------------------------------------------------------------- responder
    bit            rsp_en = 1'b0;
    bit            ack_en = 1'b1;
    int            rsp    = 0;
    int            cnt    = 0;
    int            beats  = 0;
    logic [AW-1:0] cur_addr;

    always @(posedge clk) begin
        #1;
        if (rsp_en) begin
            mem_ack    = 1'b0;
            mem_rvalid = 1'b0;
            case (rsp)
                0: if (mem_req && ack_en) begin
                    check("req_addr", mem_addr, model_addr());
                    if (words_sent == 0) first_addr = mem_addr;
                    last_addr = mem_addr;
                    bursts++;
                    cur_addr = mem_addr;
                    cnt = 3;
                    rsp = 1;
                end
                1: begin
                    check("req_hold", {mem_req, mem_addr}, {1'b1, cur_addr});
                    cnt--;
                    if (cnt == 0) begin
                        mem_ack = 1'b1;
                        rsp     = 2;
                        beats   = 0;
                    end
                end
                default: begin
                    check("req_dropped", mem_req, 1'b0);
                    mem_rvalid = 1'b1;
                    mem_rdata  = data_of(model_addr());
                    exp_q.push_back({exp_line[0], 8'(words_sent), mem_rdata});
                    words_sent++;
                    beats++;
                    if (beats == BL) rsp = 0;
                end
            endcase
        end
    end

    // ---------------------------------------------------------------- compare
    bit   cmp_en = 1'b0;
    logic exp_disp = 1'b0;
    int   ld_count = 0;
    int   ov_cycles = 0;
    int   req_cycles = 0;
    logic last_wr_bank = 1'b0;

    always @(posedge clk) exp_disp = reset ? 1'b0 : y[0];

    always @(negedge clk) begin
        if (cmp_en) begin
            if (lb_we) begin
                if (exp_q.size() == 0) begin
                    check("spurious_we", lb_we, 1'b0);
                end else begin
                    wr_t e;
                    e = exp_q.pop_front();
                    check("lb_write", {lb_bank, lb_waddr, lb_wdata}, e);
                    check("line_done", line_done, e.waddr == 8'(WPL - 1));
                    last_wr_bank = lb_bank;
                end
            end else begin
                check("line_done_idle", line_done, 1'b0);
            end
            check("disp_bank", disp_bank, reset ? 1'b0 : exp_disp);
            if (line_done) ld_count++;
            if (overrun)   ov_cycles++;
            if (mem_req)   req_cycles++;
        end
    end

    // ---------------------------------------------------------------- helpers
    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic start_line(input int line);
        exp_line   = line;
        words_sent = 0;
        bursts     = 0;
    endtask

    task automatic wait_line(input string name);
        int start;
        start = ld_count;
        for (int i = 0; i < 1500 && ld_count == start; i++) step();
        repeat (4) step();
        check({name, "_done_once"}, 64'(ld_count - start), 64'd1);
        check({name, "_words"}, 64'(words_sent), 64'(WPL));
        check({name, "_queue_empty"}, 64'(exp_q.size()), 64'd0);
    endtask

    task automatic check_quiet(input string name);
        @(negedge clk);
        check({name, "_ctrl"}, {mem_req, lb_we, lb_bank, line_done, overrun, overrun_sticky, disp_bank}, '0);
        check({name, "_addr"}, {mem_addr, lb_waddr}, '0);
        check({name, "_data"}, lb_wdata, '0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    // ---------------------------------------------------------------- stimulus
    initial begin
        int r0;
        int ov0;

        reset = 1'b1; fb_base = '0; hblank = 1'b0; vsync = 1'b0; y = '0;
        mem_ack = 1'b0; mem_rvalid = 1'b0; mem_rdata = '0;
        exp_fb = '0; start_line(0);
        repeat (3) @(posedge clk);
        check_quiet("reset_state");

        step();
        reset = 1'b0; rsp_en = 1'b1; cmp_en = 1'b1;
        repeat (3) step();

        // Line 0 from vsync: 25 bursts 0x1000..0x10C0 into bank 0.
        exp_fb = 25'h1000; start_line(0);
        fb_base = 25'h1000; vsync = 1'b1;
        step();
        vsync = 1'b0; fb_base = '0;
        wait_line("line0");
        check("line0_first_addr", first_addr, 25'h1000);
        check("line0_last_addr", last_addr, 25'h10C0);
        check("line0_bursts", 64'(bursts), 64'd25);
        check("line0_bank", last_wr_bank, 1'b0);

        // Hblank rise on line 10 fetches line 11 into bank 1, display on bank 0.
        y = 10'd10; start_line(11);
        hblank = 1'b1;
        wait_line("line11");
        check("line11_first_addr", first_addr, 25'h1898);
        check("line11_bank", last_wr_bank, 1'b1);
        check("line11_disp_bank", disp_bank, 1'b0);
        hblank = 1'b0;
        step();

        // Edges on the last active line and in vblank are ignored.
        r0 = req_cycles;
        y = 10'd359; hblank = 1'b1;
        repeat (30) step();
        check("y359_no_req", 64'(req_cycles - r0), 64'd0);
        hblank = 1'b0; step();
        y = 10'd370; hblank = 1'b1;
        repeat (30) step();
        check("vblank_no_req", 64'(req_cycles - r0), 64'd0);
        hblank = 1'b0; step();

        // Stalled ack: the next hblank rise overruns, the first fetch completes.
        ack_en = 1'b0; ov0 = ov_cycles;
        y = 10'd20; start_line(21);
        hblank = 1'b1;
        repeat (5) step();
        hblank = 1'b0;
        repeat (3) step();
        y = 10'd21; hblank = 1'b1;
        repeat (5) step();
        check("overrun_one_cycle", 64'(ov_cycles - ov0), 64'd1);
        check("overrun_sticky_set", overrun_sticky, 1'b1);
        ack_en = 1'b1;
        wait_line("line21");
        check("overrun_sticky_held", overrun_sticky, 1'b1);
        hblank = 1'b0;
        step();

        // Reset in the middle of burst 5, then stray beats and acks.
        y = 10'd30; start_line(31);
        hblank = 1'b1;
        for (int i = 0; i < 600 && words_sent < 4 * BL + 3; i++) step();
        check("burst5_reached", 64'(words_sent >= 4 * BL + 3), 64'd1);
        rsp_en = 1'b0; rsp = 0; mem_ack = 1'b0; mem_rvalid = 1'b0;
        exp_q.delete();
        hblank = 1'b0; reset = 1'b1;
        check_quiet("mid_fetch_reset");
        step(); step();
        reset = 1'b0;
        r0 = req_cycles;
        for (int i = 0; i < 6; i++) begin
            mem_rvalid = 1'b1; mem_ack = 1'b1; mem_rdata = $urandom;
            step();
        end
        mem_rvalid = 1'b0; mem_ack = 1'b0;
        repeat (3) step();
        check_quiet("stray_beats");
        check("stray_no_req", 64'(req_cycles - r0), 64'd0);
        rsp = 0; rsp_en = 1'b1;

        // Address wrap: base near the top of the 2^25 space.
        exp_fb = 25'h1FFFF9C; start_line(0);
        fb_base = 25'h1FFFF9C; vsync = 1'b1;
        step();
        vsync = 1'b0;
        wait_line("wrap_line0");
        check("wrap_line0_first_addr", first_addr, 25'h1FFFF9C);
        y = 10'd0; start_line(1);
        hblank = 1'b1;
        wait_line("wrap_line1");
        check("wrap_line1_first_addr", first_addr, 25'd100);
        hblank = 1'b0;
        repeat (3) step();

        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule : tb_video_line_fetcher
